// File: rtl/bcd_display_formatter_if.sv
// Handshake and display bus between the ALU stage, the BCD formatter and the
// 7-segment digit decoders.
interface bcd_display_formatter_if #(
  parameter int unsigned IN_W = 10
);
  logic            start;
  logic [IN_W-1:0] value;
  logic            neg;
  logic            busy;
  logic            done;
  logic            err;
  logic [3:0]      dig0;
  logic [3:0]      dig1;
  logic [3:0]      dig2;
  logic [3:0]      dig3;

  modport master (
    output start, value, neg,
    input  busy, done, err, dig0, dig1, dig2, dig3
  );

  modport slave (
    input  start, value, neg,
    output busy, done, err, dig0, dig1, dig2, dig3
  );
endinterface

// File: rtl/bcd_display_formatter.sv
// Serial double-dabble binary-to-BCD converter with leading-zero blanking and
// minus-sign placement. Display codes: 0-9 digit, 10 minus, 11 blank.
module bcd_display_formatter #(
  parameter int unsigned IN_W = 10
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  bcd_display_formatter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  localparam int unsigned CW = $clog2(IN_W + 1);

  state_t          state, state_nx;
  logic [15:0]     bcd, bcd_nx;
  logic [IN_W-1:0] sreg, sreg_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            neg_q, neg_nx;
  logic [15:0]     disp, disp_nx;
  logic            err_q, err_nx;
  logic            done_q, done_nx;

  logic [11:0]     adj;
  logic [15:0]     fmt;
  logic            fmt_err;
  int unsigned     msd;

  // With IN_W <= 13 the thousands nibble is at most 4 before the final shift,
  // so only the lower three nibbles ever need the +3 correction.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  always_comb begin
    msd = 0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    fmt     = bcd;
    fmt_err = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i > msd) fmt[4*i +: 4] = 4'd11;
    end
    if (neg_q && (bcd != '0)) begin
      if (msd == 3) begin
        fmt     = 16'hAAAA;
        fmt_err = 1'b1;
      end else begin
        fmt[4*(msd+1) +: 4] = 4'd10;
      end
    end
  end

  always_comb begin
    state_nx = state;
    bcd_nx   = bcd;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    neg_nx   = neg_q;
    disp_nx  = disp;
    err_nx   = err_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sreg_nx  = bus.value;
          neg_nx   = bus.neg;
          bcd_nx   = '0;
          cnt_nx   = CW'(IN_W);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        bcd_nx  = {bcd[14:12], adj, sreg[IN_W-1]};
        sreg_nx = sreg << 1;
        cnt_nx  = cnt - 1'b1;
        if (cnt == CW'(1)) state_nx = FORMAT;
      end
      FORMAT: begin
        disp_nx  = fmt;
        err_nx   = fmt_err;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      bcd    <= '0;
      sreg   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      disp   <= 16'hBBB0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      bcd    <= bcd_nx;
      sreg   <= sreg_nx;
      cnt    <= cnt_nx;
      neg_q  <= neg_nx;
      disp   <= disp_nx;
      err_q  <= err_nx;
      done_q <= done_nx;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.dig0 = disp[3:0];
  assign bus.dig1 = disp[7:4];
  assign bus.dig2 = disp[11:8];
  assign bus.dig3 = disp[15:12];

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed bench for bcd_display_formatter: conversions, sign/blanking corner
// cases, held start, and asynchronous reset mid-conversion.
module tb_bcd_display_formatter;

  localparam int unsigned IN_W = 10;

  logic clk = 1'b0;
  logic rst_n;

  always #10 clk = ~clk;

  bcd_display_formatter_if #(.IN_W(IN_W)) bus ();

  bcd_display_formatter #(.IN_W(IN_W)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  endfunction

  // Present start for one cycle, then scramble value/neg and wait for done.
  task automatic run_conv(input string tag, input int unsigned v, input logic n,
                          input logic [15:0] exp_d, input logic exp_e);
    int unsigned k;
    int unsigned busy_n;
    int unsigned flips;
    logic [15:0] prev;
    bit          seen;
    @(negedge clk);
    prev      = digits();
    bus.start = 1'b1;
    bus.value = IN_W'(v);
    bus.neg   = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = '1;
    bus.neg   = ~n;
    busy_n = bus.busy ? 1 : 0;
    flips  = 0;
    k      = 0;
    seen   = 1'b0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_n++;
        if (digits() !== prev) flips++;
      end
    end
    check_eq({tag, " latency"}, k, IN_W + 1);
    check_eq({tag, " busy cycles"}, busy_n, IN_W + 1);
    check_eq({tag, " digits held"}, flips, 0);
    check_eq({tag, " busy at done"}, {31'd0, bus.busy}, 0);
    check_eq({tag, " digits"}, {16'd0, digits()}, {16'd0, exp_d});
    check_eq({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_e});
    @(negedge clk);
    check_eq({tag, " done width"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_done;
    int unsigned first_i;
    int unsigned second_i;
    int unsigned dn;

    bus.start = 1'b0;
    bus.value = '0;
    bus.neg   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check_eq("reset digits", {16'd0, digits()}, 32'hBBB0);
    check_eq("reset busy", {31'd0, bus.busy}, 0);
    check_eq("reset done", {31'd0, bus.done}, 0);
    check_eq("reset err", {31'd0, bus.err}, 0);

    run_conv("1023", 1023, 1'b0, 16'h1023, 1'b0);
    run_conv("-42", 42, 1'b1, 16'hBA42, 1'b0);
    run_conv("-7", 7, 1'b1, 16'hBBA7, 1'b0);
    run_conv("-0", 0, 1'b1, 16'hBBB0, 1'b0);
    run_conv("-999", 999, 1'b1, 16'hA999, 1'b0);
    run_conv("-1000", 1000, 1'b1, 16'hAAAA, 1'b1);
    run_conv("10", 10, 1'b0, 16'hBB10, 1'b0);
    run_conv("-100", 100, 1'b1, 16'hA100, 1'b0);
    run_conv("0", 0, 1'b0, 16'hBBB0, 1'b0);

    // start held high: accepted at edge 1, re-accepted in the done cycle.
    n_done   = 0;
    first_i  = 0;
    second_i = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i > 0 && bus.done) begin
        n_done++;
        if (n_done == 1) first_i = i;
        if (n_done == 2) second_i = i;
      end
      bus.start = (i < 20);
      bus.value = IN_W'(5);
      bus.neg   = 1'b0;
    end
    bus.start = 1'b0;
    check_eq("held done count", n_done, 2);
    check_eq("held first done", first_i, 12);
    check_eq("held second done", second_i, 24);
    check_eq("held digits", {16'd0, digits()}, 32'hBBB5);

    // Asynchronous reset during SHIFT of 500.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = IN_W'(500);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort digits", {16'd0, digits()}, 32'hBBB0);
    check_eq("abort busy", {31'd0, bus.busy}, 0);
    check_eq("abort done", {31'd0, bus.done}, 0);
    check_eq("abort err", {31'd0, bus.err}, 0);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check_eq("abort no done", dn, 0);
    check_eq("abort idle busy", {31'd0, bus.busy}, 0);

    run_conv("500", 500, 1'b0, 16'hB500, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
